reg_snapshot_ctrl: RTL and testbench

- Checkpoint manager on the other side of the register-file snapshot-recovery interface.
- Captures the architectural register image from the register file whenever decode issues a predicted branch, and holds up to DEPTH in-flight checkpoints in program order.
- On a misprediction it drives the oldest checkpoint back into the register file with the recover/done/ack handshake, then flushes all checkpoints.

---
 rtl/mips_core_pkg.sv | 17 +
 rtl/snapshot_slot_store.sv | 30 +++
 rtl/reg_snapshot_ctrl.sv | 143 ++++++++++++++
 tb/tb_reg_snapshot_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared types for the register-file checkpoint logic: the recovery FSM states
// and the architectural register image.
package mips_core_pkg;

    localparam int ARCH_DATA_WIDTH = 32;
    localparam int NUM_ARCH_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        WAIT_DONE,
        ACK
    } recov_state_e;

    typedef logic [NUM_ARCH_REGS-1:0][ARCH_DATA_WIDTH-1:0] reg_image_t;

endpackage

// File: rtl/snapshot_slot_store.sv
// Checkpoint image storage: one write port at the tail slot and one
// combinational read port at the head slot.
module snapshot_slot_store
    import mips_core_pkg::*;
#(
    parameter int DATA_WIDTH = ARCH_DATA_WIDTH,
    parameter int NUM_REGS   = NUM_ARCH_REGS,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 i_wr_en,
    input  logic [TAG_WIDTH-1:0]                 i_wr_tag,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  i_wr_image,
    input  logic [TAG_WIDTH-1:0]                 i_rd_tag,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  o_rd_image
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_slots [DEPTH];

    // Slots carry no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_slots[i_wr_tag] <= i_wr_image;
        end
    end

    assign o_rd_image = r_slots[i_rd_tag];

endmodule

// File: rtl/reg_snapshot_ctrl.sv
// Checkpoint manager: captures register images on predicted branches, retires
// them in order, and replays the oldest one into the register file on a mispredict.
module reg_snapshot_ctrl
    import mips_core_pkg::*;
#(
    parameter int DATA_WIDTH = ARCH_DATA_WIDTH,
    parameter int NUM_REGS   = NUM_ARCH_REGS,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_in,
    input  logic                                 wb_uses_rw,
    input  logic [4:0]                           wb_rw_addr,
    input  logic [DATA_WIDTH-1:0]                wb_rw_data,
    input  logic                                 take_snapshot,
    output logic [TAG_WIDTH-1:0]                 snap_tag,
    output logic                                 snap_full,
    input  logic                                 resolve_valid,
    input  logic [TAG_WIDTH-1:0]                 resolve_tag,
    input  logic                                 resolve_mispredict,
    output logic                                 recover_snapshot,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_snapshot,
    input  logic                                 done,
    output logic                                 recovery_done_ack,
    output logic                                 busy,
    output logic                                 order_err
);

    localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH+1)'(DEPTH);

    recov_state_e                        r_state;
    logic [TAG_WIDTH-1:0]                r_head;
    logic [TAG_WIDTH-1:0]                r_tail;
    logic [TAG_WIDTH:0]                  r_count;

    logic                                w_idle;
    logic                                w_resolve;
    logic                                w_legal;
    logic                                w_mispredict;
    logic                                w_correct;
    logic                                w_order_err;
    logic                                w_capture;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_merged;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_head_image;

    assign w_idle       = (r_state == IDLE);
    assign snap_full    = (r_count == FULL_COUNT);
    assign snap_tag     = r_tail;
    assign w_resolve    = resolve_valid && w_idle;
    assign w_legal      = w_resolve && (r_count != '0) && (resolve_tag == r_head);
    assign w_mispredict = w_legal && resolve_mispredict;
    assign w_correct    = w_legal && !resolve_mispredict;
    assign w_order_err  = w_resolve && !w_legal;
    // Fullness is judged on the registered count, so a same-cycle retire never makes room.
    assign w_capture    = take_snapshot && !snap_full && w_idle && !w_mispredict;

    // The captured image must include the write-back landing in the same cycle.
    always_comb begin
        w_merged = regs_in;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wb_uses_rw && (wb_rw_addr == 5'(i))) begin
                w_merged[i] = wb_rw_data;
            end
        end
        w_merged[0] = '0;
    end

    snapshot_slot_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_slot_store (
        .clk        (clk),
        .i_wr_en    (w_capture),
        .i_wr_tag   (r_tail),
        .i_wr_image (w_merged),
        .i_rd_tag   (r_head),
        .o_rd_image (w_head_image)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            recover_snapshot  <= 1'b0;
            recovery_done_ack <= 1'b0;
            busy              <= 1'b0;
            order_err         <= 1'b0;
            regs_snapshot     <= '0;
        end else begin
            order_err <= w_order_err;

            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_correct) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_capture) begin
                    r_tail <= r_tail + 1'b1;
                end
                r_count <= r_count + (TAG_WIDTH+1)'(w_capture) - (TAG_WIDTH+1)'(w_correct);
            end

            case (r_state)
                IDLE: begin
                    if (w_mispredict) begin
                        regs_snapshot    <= w_head_image;
                        recover_snapshot <= 1'b1;
                        busy             <= 1'b1;
                        r_state          <= RECOVER;
                    end
                end
                RECOVER: begin
                    recover_snapshot <= 1'b0;
                    r_state          <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done) begin
                        recovery_done_ack <= 1'b1;
                        r_state           <= ACK;
                    end
                end
                ACK: begin
                    recovery_done_ack <= 1'b0;
                    busy              <= 1'b0;
                    r_state           <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_snapshot_ctrl.sv
// Scoreboard bench for reg_snapshot_ctrl: a queue-based checkpoint model predicts
// every cycle's outputs, and a separate monitor compares them on the falling edge.
module tb_reg_snapshot_ctrl;
    import mips_core_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    reg_image_t        regsIn = '0;
    logic              wbUsesRw = 1'b0;
    logic [4:0]        wbRwAddr = '0;
    logic [31:0]       wbRwData = '0;
    logic              takeSnapshot = 1'b0;
    logic [TW-1:0]     snapTag;
    logic              snapFull;
    logic              resolveValid = 1'b0;
    logic [TW-1:0]     resolveTag = '0;
    logic              resolveMispredict = 1'b0;
    logic              recoverSnapshot;
    reg_image_t        regsSnapshot;
    logic              done = 1'b0;
    logic              recoveryDoneAck;
    logic              busy;
    logic              orderErr;

    reg_snapshot_ctrl #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .regs_in            (regsIn),
        .wb_uses_rw         (wbUsesRw),
        .wb_rw_addr         (wbRwAddr),
        .wb_rw_data         (wbRwData),
        .take_snapshot      (takeSnapshot),
        .snap_tag           (snapTag),
        .snap_full          (snapFull),
        .resolve_valid      (resolveValid),
        .resolve_tag        (resolveTag),
        .resolve_mispredict (resolveMispredict),
        .recover_snapshot   (recoverSnapshot),
        .regs_snapshot      (regsSnapshot),
        .done               (done),
        .recovery_done_ack  (recoveryDoneAck),
        .busy               (busy),
        .order_err          (orderErr)
    );

    always #5 clk = ~clk;

    int cycCount = 0;
    always @(posedge clk) cycCount <= cycCount + 1;

    typedef struct {
        int            cyc;
        logic [TW-1:0] tag;
        logic          full;
        logic          busy;
        logic          rec;
        logic          ack;
        logic          oerr;
        reg_image_t    img;
    } exp_t;

    exp_t       expQ[$];
    reg_image_t ckptQ[$];
    int         headTag = 0;
    int         tailTag = 0;
    int         recoverCyc = -10;
    int         doneCyc = -10;
    int         ackCyc = -10;
    int         forcedDelay = 0;
    reg_image_t lastImage = '0;
    int         checks = 0;
    int         failures = 0;

    function automatic bit modelBusy(input int c);
        return (c >= recoverCyc) && (c <= ackCyc);
    endfunction

    task automatic checkOutput(input string name, input int cyc, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic checkImage(input string name, input int cyc, input reg_image_t act, input reg_image_t expv);
        checks++;
        if (act !== expv) begin
            failures++;
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                if (act[i] !== expv[i]) begin
                    $display("[TB] FAIL %s at cycle %0d: reg %0d got %0h, expected %0h",
                             name, cyc, i, act[i], expv[i]);
                    break;
                end
            end
        end
    endtask

    // Drives one cycle of inputs and pushes the outputs expected in the following cycle.
    task automatic applyStimulus(input bit take, input bit rv, input int rtag, input bit mp,
                                 input bit wb, input int waddr, input logic [31:0] wdata,
                                 input bit randRegs);
        int         c;
        int         d;
        bit         legal;
        bit         mispred;
        bit         capture;
        bit         oerr;
        reg_image_t img;
        exp_t       e;
        @(posedge clk);
        #1;
        c = cycCount;
        if (randRegs) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) regsIn[i] = $urandom;
        end
        takeSnapshot      = take;
        resolveValid      = rv;
        resolveTag        = TW'(rtag);
        resolveMispredict = mp;
        wbUsesRw          = wb;
        wbRwAddr          = 5'(waddr);
        wbRwData          = wdata;
        done              = (c == doneCyc);
        oerr = 1'b0;
        if (!modelBusy(c)) begin
            legal   = rv && (ckptQ.size() > 0) && (rtag == headTag);
            oerr    = rv && !legal;
            mispred = legal && mp;
            capture = take && (ckptQ.size() < DEPTH) && !mispred;
            if (mispred) begin
                lastImage = ckptQ[0];
                ckptQ.delete();
                headTag = 0;
                tailTag = 0;
                d = (forcedDelay > 0) ? forcedDelay : int'($urandom_range(1, 3));
                recoverCyc = c + 1;
                doneCyc    = c + 1 + d;
                ackCyc     = c + 2 + d;
            end else begin
                if (legal) begin
                    void'(ckptQ.pop_front());
                    headTag = (headTag + 1) % DEPTH;
                end
                if (capture) begin
                    img = regsIn;
                    if (wb && waddr != 0) img[waddr] = wdata;
                    img[0] = '0;
                    ckptQ.push_back(img);
                    tailTag = (tailTag + 1) % DEPTH;
                end
            end
        end
        e.cyc  = c + 1;
        e.tag  = TW'(tailTag);
        e.full = (ckptQ.size() == DEPTH);
        e.busy = modelBusy(c + 1);
        e.rec  = (c + 1 == recoverCyc);
        e.ack  = (c + 1 == ackCyc);
        e.oerr = oerr;
        e.img  = lastImage;
        expQ.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tagName);
        checkOutput({tagName, "_tag"}, cycCount, 64'(snapTag), 64'(0));
        checkOutput({tagName, "_full"}, cycCount, 64'(snapFull), 64'(0));
        checkOutput({tagName, "_busy"}, cycCount, 64'(busy), 64'(0));
        checkOutput({tagName, "_recover"}, cycCount, 64'(recoverSnapshot), 64'(0));
        checkOutput({tagName, "_ack"}, cycCount, 64'(recoveryDoneAck), 64'(0));
        checkOutput({tagName, "_order_err"}, cycCount, 64'(orderErr), 64'(0));
        checkImage({tagName, "_image"}, cycCount, regsSnapshot, '0);
    endtask

    // Monitor: compares each scheduled expectation in the cycle it targets.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].cyc <= cycCount) begin
                e = expQ.pop_front();
                if (e.cyc < cycCount) begin
                    checkOutput("schedule", cycCount, 64'(e.cyc), 64'(cycCount));
                end else begin
                    checkOutput("snap_tag", e.cyc, 64'(snapTag), 64'(e.tag));
                    checkOutput("snap_full", e.cyc, 64'(snapFull), 64'(e.full));
                    checkOutput("busy", e.cyc, 64'(busy), 64'(e.busy));
                    checkOutput("recover", e.cyc, 64'(recoverSnapshot), 64'(e.rec));
                    checkOutput("ack", e.cyc, 64'(recoveryDoneAck), 64'(e.ack));
                    checkOutput("order_err", e.cyc, 64'(orderErr), 64'(e.oerr));
                    checkImage("regs_snapshot", e.cyc, regsSnapshot, e.img);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;

        // Single capture then correct resolve.
        regsIn = '0;
        regsIn[5] = 32'h11;
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 1'b0);
        applyStimulus(0, 1, headTag, 0, 0, 0, 32'h0, 1'b0);
        idleCycles(1);

        // Write-back merge and entry 0 forced to zero, then full handshake.
        regsIn[7] = 32'h1;
        regsIn[0] = 32'h5;
        applyStimulus(1, 0, 0, 0, 1, 7, 32'hDEAD, 1'b0);
        forcedDelay = 1;
        applyStimulus(0, 1, headTag, 1, 0, 0, 32'h0, 1'b0);
        idleCycles(5);

        // Fill, overflow attempt, retire with a dropped capture, then wrap.
        repeat (5) applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 1'b1);
        applyStimulus(1, 1, headTag, 0, 0, 0, 32'h0, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 1'b1);
        forcedDelay = 2;
        applyStimulus(0, 1, headTag, 1, 0, 0, 32'h0, 1'b1);
        idleCycles(6);

        // Out-of-order resolve.
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 1'b1);
        applyStimulus(0, 1, 1, 0, 0, 0, 32'h0, 1'b1);
        idleCycles(2);

        // Randomized traffic.
        forcedDelay = 0;
        for (int n = 0; n < 400; n++) begin
            int tg;
            tg = ($urandom_range(0, 99) < 80) ? headTag : int'($urandom_range(0, DEPTH - 1));
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 35, tg,
                          $urandom_range(0, 99) < 25, $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 31)), $urandom, 1'b1);
        end

        // Reset in the middle of WAIT_DONE.
        idleCycles(8);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 1'b1);
        forcedDelay = 8;
        applyStimulus(0, 1, headTag, 1, 0, 0, 32'h0, 1'b0);
        idleCycles(3);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        done = 1'b0;
        ckptQ.delete();
        headTag = 0;
        tailTag = 0;
        recoverCyc = -10;
        doneCyc = -10;
        ackCyc = -10;
        lastImage = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        forcedDelay = 1;
        applyStimulus(1, 0, 0, 0, 1, 3, 32'hBEEF, 1'b1);
        applyStimulus(0, 1, 0, 1, 0, 0, 32'h0, 1'b1);
        idleCycles(6);

        repeat (3) @(negedge clk);
        #1;
        checkOutput("drain", cycCount, 64'(expQ.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
